// File: rtl/up_adc_bus_aggregator.sv
// Return-path aggregator for ADC register slaves: merges acks, read data and channel status.
// Optional bus timeout with error word and timeout counter when UP_BUS_TIMEOUT_EN is defined.
module up_adc_bus_aggregator #(
    parameter int unsigned NUM_CH         = 2,
    parameter int unsigned NUM_SLAVES     = 3,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] TIMEOUT_DATA   = 32'hDEADDEAD
) (
    input  logic                    up_clk,
    input  logic                    up_rstn,
    input  logic                    up_wreq,
    input  logic                    up_rreq,
    input  logic [NUM_SLAVES-1:0]   up_wack_s,
    input  logic [NUM_SLAVES-1:0]   up_rack_s,
    input  logic [32*NUM_SLAVES-1:0] up_rdata_s,
    input  logic [NUM_CH-1:0]       up_status_pn_err_s,
    input  logic [NUM_CH-1:0]       up_status_pn_oos_s,
    input  logic [NUM_CH-1:0]       up_status_or_s,
    input  logic                    up_timeout_clr,
    output logic                    up_wack,
    output logic                    up_rack,
    output logic [31:0]             up_rdata,
    output logic                    up_status_pn_err,
    output logic                    up_status_pn_oos,
    output logic                    up_status_or,
    output logic [7:0]              up_timeout_count
);

    typedef enum logic {StIdle, StWait} state_e;

    state_e      rd_state_q, rd_state_d;
    state_e      wr_state_q, wr_state_d;
    logic        rack_q, rack_d;
    logic        wack_q, wack_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] rdata_or;
    logic        rd_expire, wr_expire;
    logic        pn_err_q, pn_oos_q, or_q;

    always_comb begin
        rdata_or = '0;
        for (int k = 0; k < int'(NUM_SLAVES); k++) begin
            rdata_or = rdata_or | up_rdata_s[32*k +: 32];
        end
    end

    // An ack in the same cycle as expiry wins over the forced timeout ack.
    always_comb begin
        rd_state_d = rd_state_q;
        rack_d     = 1'b0;
        rdata_d    = '0;
        unique case (rd_state_q)
            StIdle: if (up_rreq) rd_state_d = StWait;
            StWait: begin
                if (|up_rack_s) begin
                    rack_d     = 1'b1;
                    rdata_d    = rdata_or;
                    rd_state_d = StIdle;
                end else if (rd_expire) begin
                    rack_d     = 1'b1;
                    rdata_d    = TIMEOUT_DATA;
                    rd_state_d = StIdle;
                end
            end
            default: rd_state_d = StIdle;
        endcase
    end

    always_comb begin
        wr_state_d = wr_state_q;
        wack_d     = 1'b0;
        unique case (wr_state_q)
            StIdle: if (up_wreq) wr_state_d = StWait;
            StWait: begin
                if ((|up_wack_s) || wr_expire) begin
                    wack_d     = 1'b1;
                    wr_state_d = StIdle;
                end
            end
            default: wr_state_d = StIdle;
        endcase
    end

    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            rd_state_q <= StIdle;
            wr_state_q <= StIdle;
            rack_q     <= 1'b0;
            wack_q     <= 1'b0;
            rdata_q    <= '0;
            pn_err_q   <= 1'b0;
            pn_oos_q   <= 1'b0;
            or_q       <= 1'b0;
        end else begin
            rd_state_q <= rd_state_d;
            wr_state_q <= wr_state_d;
            rack_q     <= rack_d;
            wack_q     <= wack_d;
            rdata_q    <= rdata_d;
            pn_err_q   <= |up_status_pn_err_s;
            pn_oos_q   <= |up_status_pn_oos_s;
            or_q       <= |up_status_or_s;
        end
    end

    assign up_rack          = rack_q;
    assign up_wack          = wack_q;
    assign up_rdata         = rdata_q;
    assign up_status_pn_err = pn_err_q;
    assign up_status_pn_oos = pn_oos_q;
    assign up_status_or     = or_q;

`ifdef UP_BUS_TIMEOUT_EN
    logic [15:0] rd_cnt_q, wr_cnt_q;
    logic        rd_to, wr_to;
    logic [7:0]  to_cnt_q, to_cnt_d;
    logic [8:0]  to_sum;

    // Counters sit at zero while idle, so the first wait cycle sees zero.
    assign rd_expire = (rd_state_q == StWait) && (rd_cnt_q == 16'(TIMEOUT_CYCLES - 1));
    assign wr_expire = (wr_state_q == StWait) && (wr_cnt_q == 16'(TIMEOUT_CYCLES - 1));
    assign rd_to     = rd_expire && !(|up_rack_s);
    assign wr_to     = wr_expire && !(|up_wack_s);
    assign to_sum    = 9'(to_cnt_q) + 9'(rd_to) + 9'(wr_to);

    always_comb begin
        if (up_timeout_clr) begin
            to_cnt_d = 8'(rd_to) + 8'(wr_to);
        end else if (to_sum > 9'd255) begin
            to_cnt_d = 8'd255;
        end else begin
            to_cnt_d = to_sum[7:0];
        end
    end

    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            to_cnt_q <= '0;
        end else begin
            rd_cnt_q <= (rd_state_q == StWait) ? rd_cnt_q + 16'd1 : '0;
            wr_cnt_q <= (wr_state_q == StWait) ? wr_cnt_q + 16'd1 : '0;
            to_cnt_q <= to_cnt_d;
        end
    end

    assign up_timeout_count = to_cnt_q;
`else
    logic unused_timeout_clr;

    assign rd_expire          = 1'b0;
    assign wr_expire          = 1'b0;
    assign unused_timeout_clr = up_timeout_clr;
    assign up_timeout_count   = '0;
`endif

endmodule

// File: tb/tb_up_adc_bus_aggregator.sv
// Randomised and directed bench for up_adc_bus_aggregator against a transaction-level model.
// Timeout scenarios only run when UP_BUS_TIMEOUT_EN is defined.
module tb_up_adc_bus_aggregator;
    localparam int NCH = 4;
    localparam int NS  = 3;
    localparam int TO  = 8;

    logic            up_clk = 1'b0;
    logic            up_rstn;
    logic            up_wreq, up_rreq, up_timeout_clr;
    logic [NS-1:0]   up_wack_s, up_rack_s;
    logic [32*NS-1:0] up_rdata_s;
    logic [NCH-1:0]  st_err, st_oos, st_or;
    logic            up_wack, up_rack;
    logic [31:0]     up_rdata;
    logic            up_status_pn_err, up_status_pn_oos, up_status_or;
    logic [7:0]      up_timeout_count;

    up_adc_bus_aggregator #(
        .NUM_CH(NCH), .NUM_SLAVES(NS), .TIMEOUT_CYCLES(TO), .TIMEOUT_DATA(32'hDEADDEAD)
    ) dut (
        .up_clk(up_clk), .up_rstn(up_rstn), .up_wreq(up_wreq), .up_rreq(up_rreq),
        .up_wack_s(up_wack_s), .up_rack_s(up_rack_s), .up_rdata_s(up_rdata_s),
        .up_status_pn_err_s(st_err), .up_status_pn_oos_s(st_oos), .up_status_or_s(st_or),
        .up_timeout_clr(up_timeout_clr), .up_wack(up_wack), .up_rack(up_rack),
        .up_rdata(up_rdata), .up_status_pn_err(up_status_pn_err),
        .up_status_pn_oos(up_status_pn_oos), .up_status_or(up_status_or),
        .up_timeout_count(up_timeout_count)
    );

    always #5 up_clk = ~up_clk;

`ifdef UP_BUS_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    int n_vec = 0;
    int n_err = 0;
    bit rand_status = 1'b0;

    // Model: busy flag plus number of wait cycles spent so far per direction.
    bit          rd_busy, wr_busy;
    int          rd_age, wr_age;
    int          m_cnt;
    logic        e_rack, e_wack, e_err, e_oos, e_or;
    logic [31:0] e_rdata;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        rd_busy = 0; wr_busy = 0; rd_age = 0; wr_age = 0; m_cnt = 0;
        e_rack = 0; e_wack = 0; e_rdata = '0; e_err = 0; e_oos = 0; e_or = 0;
    endtask

    task automatic clear_inputs();
        up_rreq = 0; up_wreq = 0; up_rack_s = '0; up_wack_s = '0;
        up_rdata_s = '0; up_timeout_clr = 0;
    endtask

    task automatic model_step();
        int inc;
        logic [31:0] word_or;
        inc = 0;
        word_or = '0;
        for (int k = 0; k < NS; k++) word_or |= up_rdata_s[32*k +: 32];
        e_rack = 0; e_wack = 0; e_rdata = '0;
        if (!rd_busy) begin
            if (up_rreq) begin rd_busy = 1; rd_age = 0; end
        end else begin
            rd_age++;
            if (up_rack_s != 0) begin
                e_rack = 1; e_rdata = word_or; rd_busy = 0;
            end else if (TO_EN && rd_age == TO) begin
                e_rack = 1; e_rdata = 32'hDEADDEAD; rd_busy = 0; inc++;
            end
        end
        if (!wr_busy) begin
            if (up_wreq) begin wr_busy = 1; wr_age = 0; end
        end else begin
            wr_age++;
            if (up_wack_s != 0) begin
                e_wack = 1; wr_busy = 0;
            end else if (TO_EN && wr_age == TO) begin
                e_wack = 1; wr_busy = 0; inc++;
            end
        end
        if (TO_EN) begin
            if (up_timeout_clr) m_cnt = inc;
            else m_cnt = (m_cnt + inc > 255) ? 255 : m_cnt + inc;
        end
        e_err = (st_err != 0); e_oos = (st_oos != 0); e_or = (st_or != 0);
    endtask

    task automatic check_outputs();
        check_eq("rack", 32'(up_rack), 32'(e_rack));
        check_eq("wack", 32'(up_wack), 32'(e_wack));
        check_eq("rdata", up_rdata, e_rdata);
        check_eq("pn_err", 32'(up_status_pn_err), 32'(e_err));
        check_eq("pn_oos", 32'(up_status_pn_oos), 32'(e_oos));
        check_eq("st_or", 32'(up_status_or), 32'(e_or));
        check_eq("to_count", 32'(up_timeout_count), 32'(m_cnt));
    endtask

    // Called just after a negedge with inputs set; checks just after the next posedge.
    task automatic tick();
        if (rand_status) begin
            st_err = NCH'($urandom); st_oos = NCH'($urandom); st_or = NCH'($urandom);
        end
        model_step();
        @(posedge up_clk);
        #1;
        check_outputs();
        @(negedge up_clk);
        clear_inputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        up_rstn = 0;
        clear_inputs();
        st_err = '0; st_oos = '0; st_or = '0;
        model_reset();
        #12;
        check_outputs();
        @(negedge up_clk);
        up_rstn = 1;

        // Slave 1 acks four cycles after the read request.
        up_rreq = 1; tick();
        idle(3);
        up_rack_s = 3'b010; up_rdata_s[63:32] = 32'h0000_1234; tick();
        check_eq("rd_1234", up_rdata, 32'h0000_1234);

        // Two slaves ack together: one pulse, ORed data.
        up_rreq = 1; tick();
        up_rack_s = 3'b101; up_rdata_s[31:0] = 32'h00F0; up_rdata_s[95:64] = 32'h0F00; tick();
        check_eq("rd_or", up_rdata, 32'h0000_0FF0);
        idle(1);
        check_eq("rack_once", 32'(up_rack), 32'd0);

        // Spurious acks while idle, and an ack coinciding with the request.
        up_rack_s = 3'b001; up_wack_s = 3'b100; tick();
        check_eq("spur_rack", 32'(up_rack), 32'd0);
        up_rreq = 1; up_rack_s = 3'b001; tick();
        up_rack_s = 3'b001; up_rdata_s[31:0] = 32'h55; tick();
        check_eq("same_cyc_req", up_rdata, 32'h55);

        // Write path.
        up_wreq = 1; tick();
        idle(2);
        up_wack_s = 3'b010; tick();
        check_eq("wack", 32'(up_wack), 32'd1);

        if (TO_EN) begin
            // Ack in the expiry cycle wins.
            up_rreq = 1; tick();
            idle(7);
            up_rack_s = 3'b100; up_rdata_s[95:64] = 32'hCAFE_0001; tick();
            check_eq("ack_wins", up_rdata, 32'hCAFE_0001);
            check_eq("ack_wins_cnt", 32'(up_timeout_count), 32'd0);
            // Plain read timeout at request+9.
            up_rreq = 1; tick();
            idle(7);
            check_eq("no_early_to", 32'(up_rack), 32'd0);
            idle(1);
            check_eq("to_rack", 32'(up_rack), 32'd1);
            check_eq("to_data", up_rdata, 32'hDEADDEAD);
            check_eq("to_cnt1", 32'(up_timeout_count), 32'd1);
            // Simultaneous read and write timeouts.
            up_rreq = 1; up_wreq = 1; tick();
            idle(8);
            check_eq("to_cnt3", 32'(up_timeout_count), 32'd3);
            for (int i = 0; i < 150; i++) begin
                up_rreq = 1; up_wreq = 1; tick();
                idle(8);
            end
            check_eq("to_sat", 32'(up_timeout_count), 32'd255);
            up_timeout_clr = 1; tick();
            check_eq("to_clr", 32'(up_timeout_count), 32'd0);
            // Clear coinciding with a timeout leaves one.
            up_rreq = 1; tick();
            idle(7);
            up_timeout_clr = 1; tick();
            check_eq("clr_inc", 32'(up_timeout_count), 32'd1);
        end else begin
            up_rreq = 1; tick();
            idle(30);
            check_eq("no_to_rack", 32'(up_rack), 32'd0);
            up_timeout_clr = 1; up_rack_s = 3'b001; up_rdata_s[31:0] = 32'h77; tick();
            check_eq("late_ack", up_rdata, 32'h77);
        end

        // Status merge.
        st_or = 4'b0100; tick();
        check_eq("status_or", 32'(up_status_or), 32'd1);
        st_or = '0; st_err = 4'b1000; tick();
        check_eq("status_err", 32'(up_status_pn_err), 32'd1);

        // Random traffic.
        rand_status = 1;
        for (int c = 0; c < 3000; c++) begin
            up_rreq = ($urandom_range(0, 5) == 0);
            up_wreq = ($urandom_range(0, 5) == 0);
            up_timeout_clr = ($urandom_range(0, 49) == 0);
            for (int k = 0; k < NS; k++) begin
                up_rack_s[k] = ($urandom_range(0, 11) == 0);
                up_wack_s[k] = ($urandom_range(0, 11) == 0);
                if (up_rack_s[k]) up_rdata_s[32*k +: 32] = $urandom;
            end
            tick();
        end
        rand_status = 0;

        // Reset in the middle of a wait.
        st_err = '1; st_oos = '1; st_or = '1;
        up_rreq = 1; up_wreq = 1; tick();
        tick();
        up_rstn = 0;
        #1;
        model_reset();
        st_err = '0; st_oos = '0; st_or = '0;
        check_outputs();
        @(negedge up_clk);
        up_rstn = 1;
        up_rack_s = 3'b111; up_wack_s = 3'b111; up_rdata_s = '1; tick();
        check_eq("rst_no_rack", 32'(up_rack), 32'd0);
        check_eq("rst_no_wack", 32'(up_wack), 32'd0);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/up_adc_bus_aggregator.md
# up_adc_bus_aggregator

Parametrised processor-bus return-path aggregator for multi-channel ADC cores. It sits between the up_axi bridge and NUM_SLAVES register slaves, which are typically NUM_CH channel blocks plus up_adc_common. It merges their read data, read acks, write acks and per-channel status into single registered outputs. It also adds what a plain OR-combine lacks: per-direction transaction tracking, spurious-ack filtering and a bus timeout that returns an error word rather than hanging the AXI bridge.

## Interface
Parameters:
- NUM_CH, 2: ADC channel count, 1..16; width of the status vectors.
- NUM_SLAVES, 3: register slaves on the bus, 1..32.
- TIMEOUT_CYCLES, 255: up_clk cycles without an ack before a forced ack; 2..65535.
- TIMEOUT_DATA, 32'hDEADDEAD: read data returned on a read timeout.

Ports:
- Clock and reset: reset up_rstn, asynchronous, active-low; clock up_clk.
- up_clk  in  1  processor clock.
- up_rstn  in  1  asynchronous active-low reset.
- up_wreq  in  1  write request pulse from the bridge.
- up_rreq  in  1  read request pulse from the bridge.
- up_wack_s  in  NUM_SLAVES  per-slave write acks.
- up_rack_s  in  NUM_SLAVES  per-slave read acks.
- up_rdata_s  in  32*NUM_SLAVES  per-slave read data; slave k occupies [32k+31:32k].
- up_status_pn_err_s  in  NUM_CH  per-channel PN error.
- up_status_pn_oos_s  in  NUM_CH  per-channel PN out-of-sync.
- up_status_or_s  in  NUM_CH  per-channel over-range.
- up_timeout_clr  in  1  clears up_timeout_count.
- up_wack  out  1  merged write ack, one-cycle pulse.
- up_rack  out  1  merged read ack, one-cycle pulse.
- up_rdata  out  32  merged read data; valid only while up_rack is high, 0 otherwise.
- up_status_pn_err, up_status_pn_oos, up_status_or  out  1 each  OR of the channel status vectors.
- up_timeout_count  out  8  saturating count of timed-out transactions.

## Operation
- Read and write paths each run their own independent FSM with states IDLE and WAIT.
- Read FSM:
  - IDLE: on up_rreq, go to WAIT and clear the counter.
  - WAIT: if any up_rack_s bit is set, drive up_rack=1 and up_rdata=OR of all slave words in the next cycle, then return to IDLE. Otherwise increment the counter.
  - When the counter reaches TIMEOUT_CYCLES-1 with no ack, drive up_rack=1 and up_rdata=TIMEOUT_DATA, increment up_timeout_count, and return to IDLE.
- Write FSM: same structure using up_wreq and up_wack_s; there is no data path.
- Acks that arrive in IDLE are spurious: drop them, generate no output pulse.
- A request that arrives while in WAIT is ignored. The bridge never issues one.
- Several slaves acking in the same cycle produce one ack pulse; their data is bitwise ORed.
- Ack and timeout expiry in the same cycle: the ack wins, normal data is returned, and the count does not increment.
- up_timeout_count saturates at 255. If up_timeout_clr and an increment happen in the same cycle, the result is 1.
- Read and write timeouts in the same cycle increment the count by 2, still saturating.
- Status outputs are registered ORs of the per-channel vectors, updated every cycle regardless of FSM state.
- Reset mid-transaction: both FSMs go to IDLE and any pending ack is lost. The bridge is reset by the same up_rstn.

## Timing
- Reset values: up_wack=0, up_rack=0, up_rdata=0, all three status outputs=0, up_timeout_count=0, FSMs in IDLE.
- Ack latency: an ack_s in cycle n gives up_rack/up_wack high in cycle n+1, for exactly one cycle.
- The earliest ack accepted is the cycle after the request. An ack in the same cycle as the request is treated as spurious.
- Timeout: with the request in cycle r and no ack, the forced ack is high in cycle r+TIMEOUT_CYCLES+1.
- Status latency: one cycle.

## Configuration
- UP_BUS_TIMEOUT_EN defined: the counters, timeout forcing and up_timeout_count are all implemented as described above.
- UP_BUS_TIMEOUT_EN undefined:
  - The counters are removed; WAIT persists until an ack arrives.
  - up_timeout_count is tied to 0 and up_timeout_clr is ignored.
  - Spurious-ack filtering and status merging are unchanged.

## Test plan
- NUM_SLAVES=3. Send up_rreq; slave 1 acks 4 cycles later with 0x00001234. Expect up_rack pulse 1 cycle after the ack with up_rdata=0x00001234.
- Two slaves ack in the same cycle with 0x00F0 and 0x0F00. Expect a single up_rack with up_rdata=0x0FF0.
- TIMEOUT_CYCLES=8 with no ack:
  - Expect up_rack at request+9 with up_rdata=0xDEADDEAD and up_timeout_count=1.
  - An ack at request+8 instead returns its real data and the count stays 0.
- up_rack_s pulse while IDLE produces no up_rack.
- Read and write issued simultaneously, both timing out, give count +2. 300 timeouts saturate the count at 255; up_timeout_clr then gives 0.
- up_status_or_s=4'b0100 with NUM_CH=4 gives up_status_or=1 one cycle later. Asserting up_rstn low mid-WAIT returns all outputs to 0 and produces no later ack.
